// File: rtl/iir_secuenciador_biquad.sv
// Serial single-multiplier biquad IIR engine that walks the coefficient ROM once per sample.
// Define IIR_SATURATE_EN to clamp the scaled output; otherwise the output wraps to cant_bits.
module iir_secuenciador_biquad #(
  parameter int cant_bits = 25,
  parameter int frac_bits = 14
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic signed [cant_bits-1:0] x_in,
  input  logic signed [cant_bits-1:0] cte,
  output logic        [3:0]           sel_cte,
  output logic signed [cant_bits-1:0] y_out,
  output logic                        done,
  output logic                        busy
);

  localparam int PW = 2 * cant_bits;
  localparam int AW = 2 * cant_bits + 3;

  typedef enum logic [1:0] {IDLE, MAC, ESCALA, LISTO} state_t;

  state_t                     state, state_next;
  logic        [2:0]          k;
  logic signed [cant_bits-1:0] xn, x1, x2, y1, y2;
  logic signed [cant_bits-1:0] operand;
  logic signed [cant_bits-1:0] ysc;
  logic signed [PW-1:0]        prod;
  logic signed [AW-1:0]        acc;

  // Coefficient index and its operand are both chosen from k in the same cycle.
  always_comb begin
    state_next = state;
    sel_cte    = 4'd0;
    operand    = '0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (start) state_next = MAC;
      MAC: begin
        case (k)
          3'd0:    begin sel_cte = 4'd5; operand = xn; end
          3'd1:    begin sel_cte = 4'd6; operand = x1; end
          3'd2:    begin sel_cte = 4'd7; operand = x2; end
          3'd3:    begin sel_cte = 4'd1; operand = y1; end
          3'd4:    begin sel_cte = 4'd2; operand = y2; end
          default: begin sel_cte = 4'd0; operand = '0; end
        endcase
        if (k == 3'd4) state_next = ESCALA;
      end
      ESCALA: state_next = LISTO;
      LISTO: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign prod = PW'(cte) * PW'(operand);

`ifdef IIR_SATURATE_EN
  localparam logic signed [AW-1:0] YMAX = {{(AW-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}};

  logic signed [AW-1:0] acc_sh;
  assign acc_sh = acc >>> frac_bits;

  always_comb begin
    if (acc_sh > YMAX)      ysc = YMAX[cant_bits-1:0];
    else if (acc_sh < YMIN) ysc = YMIN[cant_bits-1:0];
    else                    ysc = acc_sh[cant_bits-1:0];
  end
`else
  // Floor-shift and wrap in one slice: the low cant_bits of acc >>> frac_bits.
  assign ysc = acc[frac_bits +: cant_bits];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= 3'd0;
      acc   <= '0;
      xn    <= '0;
      x1    <= '0;
      x2    <= '0;
      y1    <= '0;
      y2    <= '0;
      y_out <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          xn  <= x_in;
          acc <= '0;
          k   <= 3'd0;
        end
        MAC: begin
          acc <= acc + {{(AW-PW){prod[PW-1]}}, prod};
          k   <= k + 3'd1;
        end
        ESCALA: begin
          y_out <= ysc;
          x2    <= x1;
          x1    <= xn;
          y2    <= y1;
          y1    <= ysc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/iir_secuenciador_biquad.md
Name: iir_secuenciador_biquad

Overview:
- Consumer side of the coefficient-ROM interface: a serial single-multiplier biquad IIR engine.
- Per input sample it drives `sel_cte` through the coefficient indices and reads the combinational `cte` back in the same cycle.
- It multiply-accumulates against the sample and its delay lines, then scales, saturates and presents y[n] with a one-cycle `done` pulse.
- Sits between the sample source (ADC/audio path) and the filter ROM in the FILTRO datapath.

Parameters:
- `cant_bits`, 25: width of samples, coefficients and output; signed two's complement.
- `frac_bits`, 14: fractional bits of the coefficient format (`0x4000` = 1.0).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse: `x_in` valid, begin computing one output.
- `x_in`  in  cant_bits  signed input sample x[n].
- `cte`  in  cant_bits  signed coefficient returned by the ROM for current `sel_cte`; combinational, same-cycle.
- `sel_cte`  out  4  coefficient index driven to the ROM.
- `y_out`  out  cant_bits  signed filtered sample y[n]; held until next update.
- `done`  out  1  one-cycle pulse, `y_out` newly valid.
- `busy`  out  1  high from the cycle after `start` acceptance until `done` inclusive.

Behaviour:
- Reset (synchronous, `reset`=1 at edge): state=IDLE; `sel_cte`=0, `y_out`=0, `done`=0, `busy`=0; accumulator and history x1, x2, y1, y2 all cleared.
- `reset` mid-computation aborts immediately to the reset state; no `done` is produced and history is cleared.
- Coefficient map:
  - index 5 = b0 · x[n]
  - index 6 = b1 · x1
  - index 7 = b2 · x2
  - index 1 = c1 · y1
  - index 2 = c2 · y2
  - Feedback coefficients are stored pre-negated, so all five products are added.
  - Other indices are never driven except 0 in idle.
- FSM:
  - **IDLE:** `sel_cte`=0. On `start`=1, latch `x_in` into xn, clear acc, go to MAC, k=0.
  - **MAC:** 5 cycles, k=0..4. `sel_cte` = 5, 6, 7, 1, 2 in turn. Each cycle acc += `cte` × operand (xn, x1, x2, y1, y2). After k=4 go to ESCALA.
  - **ESCALA:** ysc = acc >>> `frac_bits` (arithmetic shift, floor rounding), then limit to `cant_bits` per the macro. Register `y_out`; shift history x2←x1, x1←xn, y2←y1, y1←new y. Go to LISTO.
  - **LISTO:** `done`=1 for exactly this cycle; go to IDLE.
- Latency: `start` sampled at edge N → `done` high during cycle N+7. Minimum start-to-start spacing is 8 cycles.
- `start` while `busy`=1 is ignored; it is neither queued nor able to corrupt the computation. `start` during the LISTO cycle is also ignored.
- Arithmetic widths:
  - product is 2·`cant_bits` bits signed;
  - accumulator is 2·`cant_bits`+3 bits signed and cannot overflow over 5 terms;
  - `sel_cte` and operand selection are driven from k in the same cycle.
- `y_out` changes only in ESCALA (and on reset).

Optional Feature:
- Macro `IIR_SATURATE_EN`.
- Defined: ysc above 2^(cant_bits-1)-1 clamps to `0xFFFFFF`; below -2^(cant_bits-1) clamps to `0x1000000`. The clamped value is also what enters y1.
- Undefined: ysc is truncated to its low `cant_bits` bits (two's-complement wrap); no comparison logic.

Test Plan:
- Reset, then start with x=`0x4000`, using the ROM constants (b=1,-2,1; c1=`0x7D71`; c2=`0x1FFC287`) → `done` 7 cycles after start; `sel_cte` seen as 5, 6, 7, 1, 2; `y_out`=`0x4000`.
- Continue the impulse: x=0 → `y_out`=-655 (`0x1FFFD71`). Next x=0 → `y_out`=-637 (`0x1FFFD83`).
- Pulse `start` on every cycle for 20 cycles with x=`0x4000` → exactly 3 `done` pulses, spaced 8 cycles apart (at 7, 15, 23 cycles after the first start). `busy` never drops between accepted samples except in IDLE.
- Assert `reset` during MAC cycle k=2 → next cycle `busy`=0, `y_out`=0, no `done`. A following impulse reproduces the first case exactly (history cleared).
- With `IIR_SATURATE_EN`: x=`0xFFFFFF` then x=`0x1000000` → `y_out`=`0xFFFFFF`, then `0x1000000` (clamped). Without the macro, the second output is the wrapped low 25 bits of the exact value, not the clamp.
- Check `sel_cte`=0 and `done`=0 in every IDLE cycle. Check `done` is never high for two consecutive cycles.
